// File: rtl/gen_unpack_pkg.sv
// gen_unpack_pkg: shared types and helpers for the
// generic word-to-symbol unpacker.
package gen_unpack_pkg;

  typedef enum logic {
    IDLE,
    PKT
  } state_t;

  // Bits needed to count 0..acc_w inclusive.
  function automatic int cnt_w(input int acc_w);
    return $clog2(acc_w + 1);
  endfunction

  function automatic bit params_ok(
    input int in_w,
    input int out_w,
    input int acc_w
  );
    return in_w >= 1 && in_w <= 64 &&
           out_w >= 1 && out_w <= 64 &&
           acc_w == in_w + out_w - 1;
  endfunction

endpackage

// File: rtl/unpack_out_reg.sv
// unpack_out_reg: holding output register, valid/ready.
// Ports: load/d/d_sop/d_eop in, free + registered stream out.
module unpack_out_reg #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ready_in,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         d_sop,
  input  logic         d_eop,
  output logic         free,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         sop,
  output logic         eop
);

  assign free = !valid || ready_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
      sop   <= 1'b0;
      eop   <= 1'b0;
    end else if (free) begin
      valid <= load;
      sop   <= load && d_sop;
      eop   <= load && d_eop;
      if (load) data <= d;
    end
  end

endmodule

// File: rtl/gen_data_unpack.sv
// gen_data_unpack: IN_W-bit packet words to LSB-first
// OUT_W-bit values; sop/eop framing, backpressure, err pulse.
module gen_data_unpack
  import gen_unpack_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 7,
  parameter int ACC_W = IN_W + OUT_W - 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready_out,
  input  logic             valid_in,
  input  logic [IN_W-1:0]  data_in,
  input  logic             sop_in,
  input  logic             eop_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [OUT_W-1:0] data_out,
  output logic             sop_out,
  output logic             eop_out,
  output logic             err_out
);

  localparam int CNT_W = cnt_w(ACC_W);
  localparam logic [CNT_W-1:0] OW = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] IW = CNT_W'(IN_W);

  if (!params_ok(IN_W, OUT_W, ACC_W)) begin : g_bad_params
    $error("gen_data_unpack: illegal IN_W/OUT_W/ACC_W");
  end

  logic [ACC_W-1:0] acc, acc_sh, acc_keep, acc_nx;
  logic [CNT_W-1:0] cnt, pop_n, cnt_after, base, cnt_nx;
  state_t           state;
  logic             eop_pend, first;
  logic             free, pop, last_pop;
  logic             accept, take, restart;
  logic [OUT_W-1:0] pop_data;
  logic             pop_eop;

  always_comb begin
    pop = free &&
      (cnt >= OW || (eop_pend && cnt != '0));
    pop_n = '0;
    if (pop) pop_n = (cnt < OW) ? cnt : OW;
    cnt_after = cnt - pop_n;
    last_pop  = pop && eop_pend && cnt <= OW;
    // Held low in reset so the source sees no accept.
    ready_out = rst && cnt_after < OW &&
      (!eop_pend || last_pop);
    accept  = valid_in && ready_out;
    // Non-sop words outside a packet are swallowed.
    take    = accept && (state == PKT || sop_in);
    restart = accept && sop_in && state == PKT;
    acc_sh   = acc >> pop_n;
    acc_keep = restart ? '0 : acc_sh;
    base     = restart ? '0 : cnt_after;
    acc_nx = acc_sh;
    cnt_nx = cnt_after;
    if (take) begin
      acc_nx = acc_keep |
        (ACC_W'(data_in) << base);
      cnt_nx = base + IW;
    end
    // Zero-pad the short tail value.
    pop_data = acc[OUT_W-1:0] &
      ~({OUT_W{1'b1}} << cnt);
    pop_eop  = eop_pend && cnt <= OW;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      cnt      <= '0;
      state    <= IDLE;
      eop_pend <= 1'b0;
      first    <= 1'b0;
      err_out  <= 1'b0;
    end else begin
      acc     <= acc_nx;
      cnt     <= cnt_nx;
      err_out <= restart;
      if (pop) first <= 1'b0;
      if (take && sop_in) first <= 1'b1;
      if (last_pop) eop_pend <= 1'b0;
      if (take && eop_in) eop_pend <= 1'b1;
      if (take) state <= eop_in ? IDLE : PKT;
    end
  end

  unpack_out_reg #(.W(OUT_W)) u_out (
    .clk      (clk),
    .rst      (rst),
    .ready_in (ready_in),
    .load     (pop),
    .d        (pop_data),
    .d_sop    (first),
    .d_eop    (pop_eop),
    .free     (free),
    .valid    (valid_out),
    .data     (data_out),
    .sop      (sop_out),
    .eop      (eop_out)
  );

endmodule

// File: tb/tb_gen_data_unpack.sv
// tb_gen_data_unpack: directed stimulus against a bit-queue
// model, three width configurations.
module tb_gen_data_unpack;

  typedef struct {
    logic [63:0] d;
    bit          s;
    bit          e;
    int          cyc;
  } ev_t;

  logic clk = 0;
  logic rst = 0;
  logic valid_in = 0;
  logic [31:0] data_in = '0;
  logic sop_in = 0, eop_in = 0;
  logic ready_in = 1;

  int ph = 0, iw = 32, ow = 7;
  bit rnd_rdy = 0;
  int npass = 0, ntot = 0, cyc = 0, nerr = 0;

  logic v0, v1, v2;
  logic ro0, ro1, ro2, vo0, vo1, vo2;
  logic so0, so1, so2, eo0, eo1, eo2;
  logic er0, er1, er2;
  logic [6:0]  d0;
  logic [11:0] d1;
  logic [15:0] d2;
  logic ro, vo, so, eo, er;
  logic [63:0] dout;

  assign v0 = valid_in && (ph == 0);
  assign v1 = valid_in && (ph == 1);
  assign v2 = valid_in && (ph == 2);

  gen_data_unpack u0 (
    .clk(clk), .rst(rst), .ready_out(ro0),
    .valid_in(v0), .data_in(data_in),
    .sop_in(sop_in), .eop_in(eop_in),
    .ready_in(ready_in), .valid_out(vo0),
    .data_out(d0), .sop_out(so0),
    .eop_out(eo0), .err_out(er0));

  gen_data_unpack #(.IN_W(8), .OUT_W(12)) u1 (
    .clk(clk), .rst(rst), .ready_out(ro1),
    .valid_in(v1), .data_in(data_in[7:0]),
    .sop_in(sop_in), .eop_in(eop_in),
    .ready_in(ready_in), .valid_out(vo1),
    .data_out(d1), .sop_out(so1),
    .eop_out(eo1), .err_out(er1));

  gen_data_unpack #(.IN_W(16), .OUT_W(16)) u2 (
    .clk(clk), .rst(rst), .ready_out(ro2),
    .valid_in(v2), .data_in(data_in[15:0]),
    .sop_in(sop_in), .eop_in(eop_in),
    .ready_in(ready_in), .valid_out(vo2),
    .data_out(d2), .sop_out(so2),
    .eop_out(eo2), .err_out(er2));

  assign ro = ph == 0 ? ro0 : ph == 1 ? ro1 : ro2;
  assign vo = ph == 0 ? vo0 : ph == 1 ? vo1 : vo2;
  assign so = ph == 0 ? so0 : ph == 1 ? so1 : so2;
  assign eo = ph == 0 ? eo0 : ph == 1 ? eo1 : eo2;
  assign er = ph == 0 ? er0 : ph == 1 ? er1 : er2;
  assign dout = ph == 0 ? 64'(d0) :
                ph == 1 ? 64'(d1) : 64'(d2);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 ready_in = rnd_rdy ?
      1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    ntot++;
    if (ok) npass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  // Reference model: packet bits in a queue, cut into
  // OUT_W-bit values; abort keeps only whole values.
  bit  mq[$];
  bit  mopen = 0, mfirst = 0;
  ev_t exq[$];
  ev_t mlog[$];
  ev_t rlog[$];

  function automatic void emit(input bit e);
    ev_t x;
    int n;
    x.d = '0;
    n = mq.size() < ow ? mq.size() : ow;
    for (int i = 0; i < n; i++) x.d[i] = mq.pop_front();
    x.s = mfirst;
    x.e = e;
    x.cyc = 0;
    mfirst = 0;
    exq.push_back(x);
    mlog.push_back(x);
  endfunction

  function automatic void model_word(
    input logic [31:0] d, input bit s, input bit e);
    if (!mopen && !s) return;
    if (mopen && s) begin
      while (mq.size() >= ow) emit(0);
      mq.delete();
    end
    if (s) mfirst = 1;
    mopen = 1;
    for (int i = 0; i < iw; i++) mq.push_back(d[i]);
    while (mq.size() > ow) emit(0);
    if (e) begin
      while (mq.size() > 0) emit(mq.size() <= ow);
      mopen = 0;
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    exq.delete();
    mopen = 0;
    mfirst = 0;
  endfunction

  // Compare process.
  bit pv = 0, pr = 0;
  logic [63:0] pd = '0;
  always @(negedge clk) begin
    ev_t x;
    cyc++;
    if (!rst) begin
      pv = 0;
    end else begin
      if (pv && !pr)
        chk(vo && dout == pd, "hold", dout, pd);
      if (vo && ready_in) begin
        x.d = dout; x.s = so; x.e = eo; x.cyc = cyc;
        rlog.push_back(x);
        if (exq.size() == 0) begin
          chk(0, "unexpected_value", dout, 0);
        end else begin
          x = exq.pop_front();
          chk(dout == x.d && so == x.s && eo == x.e,
              "value", {dout[59:0], 1'b0, so, 1'b0, eo},
              {x.d[59:0], 1'b0, x.s, 1'b0, x.e});
        end
      end
      if (er) nerr++;
      pv = vo;
      pr = ready_in;
      pd = dout;
    end
  end

  task automatic send(input logic [31:0] d, input bit s,
                      input bit e, input bit drop = 0);
    int n;
    valid_in = 1; data_in = d; sop_in = s; eop_in = e;
    model_word(d, s, e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ro && n < 300);
    if (!ro) chk(0, "accept_timeout", 0, 1);
    if (drop) chk(ro && n == 1, "drop_ready", 64'(n), 1);
    @(posedge clk);
    #1;
    valid_in = 0; sop_in = 0; eop_in = 0;
  endtask

  task automatic send_pkt(input int n,
                          input logic [31:0] seed);
    for (int i = 0; i < n; i++)
      send(seed ^ (32'(i) * 32'h9E37_79B9),
           i == 0, i == n - 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exq.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk(exq.size() == 0 && !vo, "drain",
        64'(exq.size()), 0);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] w1 [7] = '{32'hF00CC05A, 32'h7D000007,
    32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F,
    32'hA5A5A5A5, 32'hDEADBEEF};
  logic [6:0] lit1 [9] = '{7'h5A, 7'h00, 7'h33, 7'h00,
    7'h7F, 7'h00, 7'h00, 7'h00, 7'h7D};
  logic [6:0] lit2 [5] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F,
    7'h0F};

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    chk(ro == 0, "rst_ready_out", 64'(ro), 0);
    chk(vo == 0, "rst_valid_out", 64'(vo), 0);
    chk(dout == 0, "rst_data_out", dout, 0);
    chk(so == 0, "rst_sop_out", 64'(so), 0);
    chk(eo == 0, "rst_eop_out", 64'(eo), 0);
    chk(er == 0, "rst_err_out", 64'(er), 0);
    @(posedge clk);
    #1 rst = 1;

    // Seven-word packet, 224 bits, 32 values.
    mlog.delete();
    for (int i = 0; i < 7; i++) send(w1[i], i == 0, i == 6);
    for (int i = 0; i < 9; i++)
      chk(mlog[i].d == 64'(lit1[i]), "pin_pkt7",
          mlog[i].d, 64'(lit1[i]));
    chk(mlog.size() == 32, "pin_pkt7_len",
        64'(mlog.size()), 32);
    chk(mlog[0].s && mlog[31].e && mlog[31].d == 64'h6F,
        "pin_pkt7_ends", mlog[31].d, 64'h6F);
    drain();

    // Single all-ones word: padded tail.
    mlog.delete();
    send(32'hFFFFFFFF, 1, 1);
    for (int i = 0; i < 5; i++)
      chk(mlog[i].d == 64'(lit2[i]) && mlog[i].e == (i == 4),
          "pin_single", mlog[i].d, 64'(lit2[i]));
    drain();

    // Back-to-back packets, no output bubble.
    rlog.delete();
    send_pkt(7, 32'h1357_9BDF);
    send_pkt(7, 32'h2468_ACE0);
    drain();
    chk(rlog.size() == 64, "b2b_count",
        64'(rlog.size()), 64);
    if (rlog.size() == 64)
      chk(rlog[63].cyc - rlog[0].cyc == 63, "b2b_gap",
          64'(rlog[63].cyc - rlog[0].cyc), 63);

    // Words outside a packet are dropped.
    rlog.delete();
    send(32'hDEAD0001, 0, 0, 1);
    send(32'hDEAD0002, 0, 1, 1);
    send(32'h01234567, 1, 1);
    drain();
    send(32'hDEAD0003, 0, 0, 1);
    repeat (4) @(negedge clk);
    chk(rlog.size() == 5, "drop_count",
        64'(rlog.size()), 5);
    @(posedge clk);
    #1;

    // Random downstream backpressure.
    rnd_rdy = 1;
    send_pkt(3, 32'hCAFE_0001);
    send_pkt(7, 32'hBEEF_0002);
    send_pkt(2, 32'h5555_AAAA);
    drain();
    rnd_rdy = 0;

    // sop inside an open packet.
    nerr = 0;
    send(32'h11111111, 1, 0);
    send(32'h22222222, 0, 0);
    send(32'h33333333, 1, 0);
    send(32'h44444444, 0, 1);
    drain();
    chk(nerr == 1, "err_pulse", 64'(nerr), 1);

    // Reset in the middle of a packet.
    send(32'h0BAD_F00D, 1, 0);
    send(32'h0BAD_BEEF, 0, 0);
    rst = 0;
    model_reset();
    #1;
    chk(ro == 0 && vo == 0 && dout == 0 &&
        so == 0 && eo == 0 && er == 0, "midrst_outs",
        {ro, vo, so, eo, er}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    send_pkt(4, 32'h7777_0F0F);
    drain();

    // IN_W=8, OUT_W=12.
    ph = 1; iw = 8; ow = 12;
    send_pkt(3, 32'h0000_00A5);
    send_pkt(5, 32'h0000_003C);
    rnd_rdy = 1;
    send_pkt(7, 32'h0000_0081);
    drain();
    rnd_rdy = 0;

    // IN_W=16, OUT_W=16.
    ph = 2; iw = 16; ow = 16;
    send_pkt(1, 32'h0000_1234);
    send_pkt(4, 32'h0000_F0E1);
    rnd_rdy = 1;
    send_pkt(3, 32'h0000_8001);
    drain();
    rnd_rdy = 0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/gen_data_unpack.md
Name: gen_data_unpack

Overview:
- Parametrised width converter: unpacks an IN_W-bit packetised word stream into an LSB-first stream of OUT_W-bit values.
- Successor to the fixed 32-to-7 unpacker. Adds generic widths, output-side backpressure, a sop-abort error flag, and zero-bubble packet turnaround.
- Sits between a packet source (valid/ready, sop/eop) and a narrow-symbol consumer (for example a 7-bit line encoder).

Parameters:
- IN_W, 32, input word width; range 1..64.
- OUT_W, 7, output value width; range 1..64; OUT_W > IN_W is legal.
- ACC_W, IN_W+OUT_W-1, accumulator width; derived, must not be overridden.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- ready_out  out  1  input word is accepted when valid_in && ready_out.
- valid_in  in  1  input word valid.
- data_in  in  IN_W  LSB-aligned input word.
- sop_in  in  1  first word of packet.
- eop_in  in  1  last word of packet.
- ready_in  in  1  downstream can take the output value.
- valid_out  out  1  output value valid.
- data_out  out  OUT_W  output value.
- sop_out  out  1  first value of packet.
- eop_out  out  1  last value of packet.
- err_out  out  1  one-cycle pulse: sop_in received while a packet is open.

Behaviour:
- Reset (rst=0, async): all outputs 0 (ready_out, valid_out, data_out, sop_out, eop_out, err_out); acc=0, cnt=0, state=IDLE, eop_pend=0, first=0.
- State: IDLE (no packet open) / PKT (packet open). eop_pend is set once the eop word has been absorbed.
- Output register: holds its value while valid_out && !ready_in. It is free when !valid_out || ready_in.
- Pop condition (combinational): free && (cnt >= OUT_W || (eop_pend && cnt > 0)).
  - pop emits acc[OUT_W-1:0]; bits at index >= cnt are forced to 0 (zero-pad the tail).
  - sop_out = first; first is then cleared.
  - eop_out = eop_pend && cnt <= OUT_W.
- cnt_after = cnt - (pop ? min(cnt,OUT_W) : 0).
- last_pop = pop && eop_pend && cnt <= OUT_W.
- ready_out (combinational) = cnt_after < OUT_W && (!eop_pend || last_pop).
- Accept: the word is written into acc at bit cnt_after (after the right-shift by the popped amount). cnt = cnt_after + IN_W. Pop and push happen in the same cycle.
- IDLE handling:
  - A word without sop_in is accepted and discarded (ready_out=1, no state change).
  - A word with sop_in opens the packet: state=PKT, first=1.
  - sop_in && eop_in on one word is a single-word packet.
- eop word accepted: eop_pend=1, state=IDLE.
- last_pop: eop_pend=0 and cnt reaches 0. A sop word accepted in the same cycle starts the next packet with no output gap.
- sop_in accepted in PKT (no prior eop):
  - residual acc discarded (cnt=0 before the append);
  - the new packet starts (first=1);
  - err_out pulses one cycle later.
  - Values already emitted are not retro-flagged with eop.
- Latency: word accepted at edge k -> its first value on data_out after edge k+1 (2 edges).
- Throughput: with IN_W >= OUT_W, valid_in=1 continuously and ready_in=1, valid_out stays 1 with no gaps, within and across packets. With OUT_W > IN_W, output rate is bounded by the input rate.
- Backpressure: ready_in=0 freezes the output register and suppresses pop. ready_out then drops once cnt_after >= OUT_W.
- Output-side values are never lost or duplicated.

Decomposition:
- Package gen_unpack_pkg:
  - CNT_W = $clog2(ACC_W+1);
  - state enum {IDLE, PKT};
  - parameter-legality check function.
- Sub-module unpack_out_reg: the holding output register with valid/ready, parametrised on OUT_W. It carries the data, sop, eop and valid flags.
- Accumulator, cnt and FSM stay in the top module.

Test Plan:
- Default widths, ready_in=1. Words 0xF00CC05A (sop), 0x7D000007, then 5 more words, the last with eop (7 words, 224 bits) -> 32 contiguous values: 0x5A,0x00,0x33,0x00,0x7F,0x00,0x00,0x00,0x7D,... The first has sop_out; the 32nd has eop_out and a non-padded value.
- Single word 0xFFFFFFFF with sop+eop -> 0x7F x4, then 0x0F with eop_out; the upper 3 bits of the last value are zero.
- Two 7-word packets back-to-back, valid_in held high -> 64 values with zero idle cycles between the eop_out value and the next sop_out value.
- Words sent without sop before a packet, and between eop and the next sop -> dropped; ready_out=1 for each; no valid_out.
- Random ready_in toggling (50%) on a 3-packet run -> output sequence identical to the ready_in=1 run. The held value is stable while ready_in=0.
- sop mid-packet -> err_out pulses once; the new packet's values are correct. Assert rst=0 mid-packet -> all outputs 0 immediately; a clean packet afterwards is correct.
- Param sweeps: IN_W=8/OUT_W=12 and IN_W=16/OUT_W=16 checked against a bit-queue reference model.
